// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals of the shared data-memory port
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic        ls_signed;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic        ls_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata, mem_rdata,
    output if_ack, if_rdata, if_err, ls_ack, ls_rdata, ls_err, mem_addr, mem_wdata, mem_write, mem_read
  );
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata, mem_rdata,
    input  if_ack, if_rdata, if_err, ls_ack, ls_rdata, ls_err, mem_addr, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one word memory between fetch and load/store with sub-word RMW, big-endian
module mem_port_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, ACC, WR, RESP} state_t;
  state_t      state_q, state_d;
  logic        last_ls_q, last_ls_d;
  logic        gnt_ls_q, gnt_ls_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic        pick_ls, mis;
  logic [1:0]  req_size;
  logic [31:0] req_addr, shifted, ext, lane, merged, word_addr;
  assign pick_ls   = bus.ls_req & (~bus.if_req | (RR_EN & ~last_ls_q));
  assign req_size  = pick_ls ? bus.ls_size : 2'b10;
  assign req_addr  = pick_ls ? bus.ls_addr : bus.if_addr;
  assign mis       = (req_size == 2'b11) | ((req_size == 2'b01) & req_addr[0]) | ((req_size == 2'b10) & |req_addr[1:0]);
  assign word_addr = {addr_q[31:2], 2'b00};
  assign shifted   = bus.mem_rdata << {addr_q[1:0], 3'b000};
  assign ext       = size_q == 2'b00 ? {{24{sgn_q & shifted[31]}}, shifted[31:24]} :
                     size_q == 2'b01 ? {{16{sgn_q & shifted[31]}}, shifted[31:16]} : bus.mem_rdata;
  assign lane      = size_q == 2'b00 ? 32'hFF00_0000 >> {addr_q[1:0], 3'b000} : 32'hFFFF_0000 >> {addr_q[1], 4'b0000};
  assign merged    = (bus.mem_rdata & ~lane) | ((size_q == 2'b00 ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}}) & lane);
  assign busy      = state_q != IDLE;
  assign bus.if_rdata = if_rdata_q;
  assign bus.ls_rdata = ls_rdata_q;
  // state and latched request; async reset drops strobes and discards a pending RMW write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_ls_q  <= 1'b1;
      gnt_ls_q   <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      wbuf_q     <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_ls_q  <= last_ls_d;
      gnt_ls_q   <= gnt_ls_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      wbuf_q     <= wbuf_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end
  // grant, memory sequencing and response pulses
  always_comb begin
    state_d       = state_q;
    last_ls_d     = last_ls_q;
    gnt_ls_d      = gnt_ls_q;
    we_d          = we_q;
    size_d        = size_q;
    sgn_d         = sgn_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    err_d         = err_q;
    wbuf_d        = wbuf_q;
    if_rdata_d    = if_rdata_q;
    ls_rdata_d    = ls_rdata_q;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    bus.if_ack    = 1'b0;
    bus.ls_ack    = 1'b0;
    bus.if_err    = 1'b0;
    bus.ls_err    = 1'b0;
    case (state_q)
      IDLE: if (bus.if_req | bus.ls_req) begin
        gnt_ls_d  = pick_ls;
        last_ls_d = pick_ls;
        we_d      = pick_ls & bus.ls_we;
        size_d    = req_size;
        sgn_d     = pick_ls & bus.ls_signed;
        addr_d    = req_addr;
        wdata_d   = bus.ls_wdata;
        err_d     = mis;
        state_d   = mis ? RESP : ACC;
      end
      ACC: begin
        bus.mem_addr = word_addr;
        if (we_q && size_q == 2'b10) begin
          bus.mem_write = 1'b1;
          bus.mem_wdata = wdata_q;
          state_d       = RESP;
        end else if (we_q) begin
          bus.mem_read = 1'b1;
          wbuf_d       = merged;
          state_d      = WR;
        end else begin
          bus.mem_read = 1'b1;
          ls_rdata_d   = gnt_ls_q ? ext : ls_rdata_q;
          if_rdata_d   = gnt_ls_q ? if_rdata_q : bus.mem_rdata;
          state_d      = RESP;
        end
      end
      WR: begin
        bus.mem_addr  = word_addr;
        bus.mem_write = 1'b1;
        bus.mem_wdata = wbuf_q;
        state_d       = RESP;
      end
      RESP: begin
        bus.if_ack = ~gnt_ls_q;
        bus.ls_ack = gnt_ls_q;
        bus.if_err = ~gnt_ls_q & err_q;
        bus.ls_err = gnt_ls_q & err_q;
        state_d    = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors, randomized ops against a byte-level model, arbitration and reset corners
module tb_mem_port_arbiter;
  logic clk, rst_n, busy1, busy0;
  int checks = 0, failures = 0;
  logic [31:0] mem [64];
  logic [7:0]  refb [256];
  mem_port_arbiter_if a ();
  mem_port_arbiter_if b ();
  mem_port_arbiter #(.RR_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(a.slave), .busy(busy1));
  mem_port_arbiter #(.RR_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b.slave), .busy(busy0));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (a.mem_write) mem[a.mem_addr[7:2]] <= a.mem_wdata;
  assign a.mem_rdata = mem[a.mem_addr[7:2]];
  assign b.mem_rdata = 32'h0;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [7:0]  rdm;
    logic [7:0]  wrm;
  } vec_t;
  vec_t tv [16];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void ref_ls(input logic we, input logic [1:0] sz, input logic sg, input logic [7:0] ad,
                                 input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
    int nb;
    nb  = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    er  = (sz == 2'd3) || (int'(ad) % nb != 0);
    lat = er ? 1 : (we && nb < 4) ? 3 : 2;
    rd  = '0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < nb; i++) refb[int'(ad) + i] = wd[8*(nb-1-i) +: 8];
      end else begin
        for (int i = 0; i < nb; i++) rd = {rd[23:0], refb[int'(ad) + i]};
        if (sg && nb < 4 && rd[8*nb-1]) rd = rd | (32'hFFFF_FFFF << (8*nb));
      end
    end
  endfunction

  function automatic void ref_if(input logic [7:0] ad, output logic [31:0] rd, output logic er, output int lat);
    er  = ad[1:0] != 2'b00;
    lat = er ? 1 : 2;
    rd  = '0;
    if (!er) for (int i = 0; i < 4; i++) rd = {rd[23:0], refb[int'(ad) + i]};
  endfunction

  task automatic ls_op(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] ad, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat, output logic [7:0] rdm, output logic [7:0] wrm);
    a.ls_we = we; a.ls_size = sz; a.ls_signed = sg; a.ls_addr = ad; a.ls_wdata = wd; a.ls_req = 1'b1;
    lat = -1; rd = '0; er = 1'b0; rdm = '0; wrm = '0;
    for (int n = 1; n <= 7 && lat < 0; n++) begin
      @(posedge clk); #1;
      rdm[n] = a.mem_read;
      wrm[n] = a.mem_write;
      if (a.ls_ack) begin
        lat = n; rd = a.ls_rdata; er = a.ls_err;
      end
    end
    a.ls_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic if_op(input logic [31:0] ad, output logic [31:0] rd, output logic er, output int lat);
    a.if_addr = ad; a.if_req = 1'b1;
    lat = -1; rd = '0; er = 1'b0;
    for (int n = 1; n <= 7 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (a.if_ack) begin
        lat = n; rd = a.if_rdata; er = a.if_err;
      end
    end
    a.if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] ard, erd, ew;
    logic aer, eer, saw;
    int alat, elat, na, nb;
    logic [7:0] rdm, wrm, rad;
    logic [1:0] rsz;
    logic rwe, rsg;
    logic [31:0] rwd;
    logic [3:0] seqa, seqb;
    rst_n = 1'b0;
    a.if_req = 0; a.if_addr = 0; a.ls_req = 0; a.ls_we = 0; a.ls_size = 0; a.ls_signed = 0; a.ls_addr = 0; a.ls_wdata = 0;
    b.if_req = 0; b.if_addr = 0; b.ls_req = 0; b.ls_we = 0; b.ls_size = 0; b.ls_signed = 0; b.ls_addr = 0; b.ls_wdata = 0;
    #3;
    chk("rst_busy", busy1, 0);
    chk("rst_mem_read", a.mem_read, 0);
    chk("rst_mem_write", a.mem_write, 0);
    chk("rst_mem_addr", a.mem_addr, 0);
    chk("rst_acks", {a.if_ack, a.ls_ack}, 0);
    chk("rst_rdata", a.ls_rdata | a.if_rdata, 0);
    do_reset();
    for (int w = 0; w < 64; w++) begin
      rwd = $urandom;
      ref_ls(1'b1, 2'b10, 1'b0, 8'(w * 4), rwd, erd, eer, elat);
      ls_op(1'b1, 2'b10, 1'b0, 32'(w * 4), rwd, ard, aer, alat, rdm, wrm);
    end
    tv[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 8'h00, 8'h02};
    tv[1]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 8'h02, 8'h00};
    tv[2]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0,        1'b0, 2, 8'h00, 8'h02};
    tv[3]  = '{1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 32'h0,        1'b0, 3, 8'h02, 8'h04};
    tv[4]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h11AA3344, 1'b0, 2, 8'h02, 8'h00};
    tv[5]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h1122B3F4, 32'h0,        1'b0, 2, 8'h00, 8'h02};
    tv[6]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'hFFFFFFF4, 1'b0, 2, 8'h02, 8'h00};
    tv[7]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'h000000F4, 1'b0, 2, 8'h02, 8'h00};
    tv[8]  = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'hFFFFB3F4, 1'b0, 2, 8'h02, 8'h00};
    tv[9]  = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'h00001122, 1'b0, 2, 8'h02, 8'h00};
    tv[10] = '{1'b0, 2'b10, 1'b0, 32'h12, 32'h0,        32'h0,        1'b1, 1, 8'h00, 8'h00};
    tv[11] = '{1'b0, 2'b01, 1'b1, 32'h13, 32'h0,        32'h0,        1'b1, 1, 8'h00, 8'h00};
    tv[12] = '{1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678, 32'h0,        1'b1, 1, 8'h00, 8'h00};
    tv[13] = '{1'b1, 2'b01, 1'b0, 32'h12, 32'hCAFE5566, 32'h0,        1'b0, 3, 8'h02, 8'h04};
    tv[14] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h11225566, 1'b0, 2, 8'h02, 8'h00};
    tv[15] = '{1'b0, 2'b00, 1'b1, 32'h10, 32'h0,        32'h00000011, 1'b0, 2, 8'h02, 8'h00};
    for (int i = 0; i < 16; i++) begin
      ref_ls(tv[i].we, tv[i].sz, tv[i].sg, tv[i].ad[7:0], tv[i].wd, erd, eer, elat);
      ls_op(tv[i].we, tv[i].sz, tv[i].sg, tv[i].ad, tv[i].wd, ard, aer, alat, rdm, wrm);
      chk($sformatf("tv%0d_lat", i), 32'(alat), 32'(tv[i].lat));
      chk($sformatf("tv%0d_err", i), aer, tv[i].er);
      chk($sformatf("tv%0d_rdmask", i), rdm, tv[i].rdm);
      chk($sformatf("tv%0d_wrmask", i), wrm, tv[i].wrm);
      if (!tv[i].we && !tv[i].er) chk($sformatf("tv%0d_rdata", i), ard, tv[i].rd);
    end
    if_op(32'h10, ard, aer, alat);
    chk("if_word", ard, 32'h11225566);
    chk("if_lat", 32'(alat), 2);
    if_op(32'h05, ard, aer, alat);
    chk("if_mis_err", aer, 1);
    chk("if_mis_lat", 32'(alat), 1);
    chk("if_rdata_hold", ard, 32'h11225566);
    for (int k = 0; k < 150; k++) begin
      rad = 8'($urandom_range(0, 255));
      rsz = 2'($urandom_range(0, 3));
      rwe = 1'($urandom);
      rsg = 1'($urandom);
      rwd = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        ref_if(rad, erd, eer, elat);
        if_op({24'h0, rad}, ard, aer, alat);
      end else begin
        ref_ls(rwe, rsz, rsg, rad, rwd, erd, eer, elat);
        ls_op(rwe, rsz, rsg, {24'h0, rad}, rwd, ard, aer, alat, rdm, wrm);
        if (rwe) eer = eer | 1'b0;
      end
      chk($sformatf("rnd%0d_lat", k), 32'(alat), 32'(elat));
      chk($sformatf("rnd%0d_err", k), aer, eer);
      if (!eer && !(a.ls_we && a.ls_req === 1'b0 && rwe && erd == 0 && elat == 3) && elat == 2 && erd !== 32'hx)
        if (!(rwe && ard === a.ls_rdata && elat == 2 && erd == 0)) chk($sformatf("rnd%0d_rdata", k), ard, erd);
    end
    do_reset();
    a.if_addr = 32'h20; a.ls_we = 0; a.ls_size = 2'b10; a.ls_signed = 0; a.ls_addr = 32'h24;
    b.if_addr = 32'h20; b.ls_we = 0; b.ls_size = 2'b10; b.ls_signed = 0; b.ls_addr = 32'h24;
    a.if_req = 1; a.ls_req = 1; b.if_req = 1; b.ls_req = 1;
    na = 0; nb = 0; seqa = '0; seqb = '0;
    for (int n = 0; n < 40 && (na < 4 || nb < 4); n++) begin
      @(posedge clk); #1;
      if (na < 4 && (a.if_ack || a.ls_ack)) begin seqa[na] = a.ls_ack; na++; end
      if (nb < 4 && (b.if_ack || b.ls_ack)) begin seqb[nb] = b.ls_ack; nb++; end
    end
    a.if_req = 0; a.ls_req = 0; b.if_req = 0; b.ls_req = 0;
    @(posedge clk); #1;
    chk("rr_count", 32'(na), 4);
    chk("rr_seq", seqa, 4'b1010);
    chk("fp_count", 32'(nb), 4);
    chk("fp_seq", seqb, 4'b0000);
    ew = {refb[16], refb[17], refb[18], refb[19]};
    a.ls_we = 1; a.ls_size = 2'b00; a.ls_signed = 0; a.ls_addr = 32'h11; a.ls_wdata = 32'h000000AA; a.ls_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_wr_strobe_on", a.mem_write, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wr_strobe_off", a.mem_write, 0);
    chk("rst_wr_busy", busy1, 0);
    chk("rst_wr_ack", a.ls_ack, 0);
    a.ls_req = 0;
    @(posedge clk); #1;
    chk("rst_wr_mem", mem[4], ew);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      saw = saw | a.ls_ack | a.if_ack;
    end
    chk("rst_wr_noack", saw, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
